ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch stage of the single-issue RV32I core. It holds the program counter, fetches one 32-bit word per instruction from instruction memory with a req/ready handshake, and presents the fetched word to decode with a valid/ready handshake. Decode drives the extension selector and immediate generator from this `instr`. It also consumes the sign-extended immediate produced downstream to compute branch, JAL and JALR redirect targets.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  word-aligned fetch address (current PC)
- imem_rdata  in  32  instruction word; valid when imem_ready=1
- imem_ready  in  1  memory returns data for imem_addr this cycle
- instr  out  32  fetched instruction to decode
- instr_pc  out  32  PC of `instr`
- instr_valid  out  1  `instr`/`instr_pc` valid
- instr_ready  in  1  decode accepts `instr` this cycle
- redirect  in  1  taken branch/jump from execute
- redirect_base  in  32  PC of the jump/branch, or rs1 for JALR
- redirect_imm  in  32  sign-extended immediate (I/B/J format as selected by decode)
- redirect_jalr  in  1  clear target bit 0 (JALR semantics)
- fetch_fault  out  1  misaligned-target fault (see Configuration)

## Operation
- State machine: REQ, HOLD, FAULT.
- REQ: imem_req=1, imem_addr=pc. On imem_ready: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, go to HOLD.
- HOLD: imem_req=0, instr_valid=1, instr/instr_pc stable. On instr_ready: pc<=pc+4, instr_valid<=0, go to REQ.
- PC increment wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- Target = (redirect_base + redirect_imm) mod 2^32. If redirect_jalr=1, clear bit 0.
- redirect has priority over everything in every state:
  - pc<=target and instr_valid<=0.
  - Any imem_ready in the same cycle is discarded.
  - Any instr_ready in the same cycle is ignored; no pc+4.
  - Next state is REQ, or FAULT (see Configuration).
- FAULT: imem_req=0, instr_valid=0, fetch_fault=1. Left only by a redirect to an aligned target, or by reset.
- Memory contract: while imem_req=1 and no redirect, imem_addr is held stable until imem_ready.

## Timing
- Reset (async assert): pc=RESET_PC, state=REQ, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, instr_valid=0, fetch_fault=0.
- imem_req=1 from the first cycle after rst_n deasserts.
- imem_req and imem_addr are decoded from registered state; no combinational path from inputs.
- Latency: the imem_ready cycle is edge N; instr_valid=1 from edge N+1.
- With zero-wait memory and instr_ready tied high, sustained rate is 1 instruction per 2 cycles.
- Redirect asserted in cycle N: imem_addr=target and imem_req=1 in cycle N+1; instr_valid=0 in cycle N+1.
- Reset mid-transaction: any pending fetch or held instruction is dropped and the unit restarts at RESET_PC.

## Configuration
- IFETCH_MISALIGN_TRAP_EN defined:
  - A redirect target with bit 1 set (after any JALR bit-0 clear) enters FAULT. fetch_fault=1 from the next cycle; no memory request is issued.
  - pc still loads the raw target, for debug.
- Undefined:
  - Target bits [1:0] are forced to 00 silently.
  - FAULT is unreachable; fetch_fault is tied to 0.

## Test plan
- Reset release, RESET_PC=0, zero-wait memory returning 32'h0000_0013, instr_ready=1 → fetch addresses 0,4,8,…; instr_valid pulses every other cycle with instr_pc tracking.
- imem_ready delayed 3 cycles at addr 8 → imem_addr held at 8 and imem_req=1 throughout; instr_valid not asserted early.
- Decode stall: instr_ready=0 for 4 cycles in HOLD → instr and instr_pc stable, imem_req=0, pc unchanged; after acceptance next fetch is pc+4.
- Redirect in the same cycle as imem_ready: base=32'h100, imm=32'hFFFF_FFF0 → returned word discarded, next imem_addr=32'hF0, instr_valid=0.
- JALR redirect: base=32'h201, imm=32'h4, jalr=1 → target 32'h204 fetched. PC wrap: pc=32'hFFFF_FFFC accepted → next imem_addr=0.
- Misaligned target 32'h102:
  - With IFETCH_MISALIGN_TRAP_EN: fetch_fault=1, imem_req=0 until a redirect to 32'h200, which clears the fault and fetches 32'h200.
  - Without the macro: fetch at 32'h100.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, req/ready fetch from imem, valid/ready handoff to decode.
// Optional IFETCH_MISALIGN_TRAP_EN: misaligned redirect targets enter FAULT instead of being forced aligned.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_base,
  input  logic [31:0] redirect_imm,
  input  logic        redirect_jalr,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {StReq, StHold, StFault} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] target_sum;
  logic [31:0] target;

  assign target_sum = redirect_base + redirect_imm;
  assign target     = {target_sum[31:1], target_sum[0] & ~redirect_jalr};

  // Memory-side outputs come straight from registered state.
  assign imem_req  = (state_q == StReq);
  assign imem_addr = pc_q;

`ifndef IFETCH_MISALIGN_TRAP_EN
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StReq;
      pc_q        <= RESET_PC;
      instr       <= 32'h0000_0013;
      instr_pc    <= RESET_PC;
      instr_valid <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      fetch_fault <= 1'b0;
`endif
    end else if (redirect) begin
      // Redirect wins: any returned word or decode acceptance this cycle is dropped.
      instr_valid <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      if (target[1]) begin
        pc_q        <= target;
        state_q     <= StFault;
        fetch_fault <= 1'b1;
      end else begin
        pc_q        <= target & ~32'h3;
        state_q     <= StReq;
        fetch_fault <= 1'b0;
      end
`else
      pc_q    <= target & ~32'h3;
      state_q <= StReq;
`endif
    end else begin
      unique case (state_q)
        StReq: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            instr_pc    <= pc_q;
            instr_valid <= 1'b1;
            state_q     <= StHold;
          end
        end
        StHold: begin
          if (instr_ready) begin
            pc_q        <= pc_q + 32'd4;
            instr_valid <= 1'b0;
            state_q     <= StReq;
          end
        end
        default: begin
          // StFault: held until an aligned redirect or reset.
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit; outputs sampled and inputs driven on the falling edge.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_base;
  logic [31:0] redirect_imm;
  logic        redirect_jalr;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  ifetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect      (redirect),
    .redirect_base (redirect_base),
    .redirect_imm  (redirect_imm),
    .redirect_jalr (redirect_jalr),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_redirect(input logic [31:0] base, input logic [31:0] imm, input logic jalr);
    redirect      = 1'b1;
    redirect_base = base;
    redirect_imm  = imm;
    redirect_jalr = jalr;
    step;
    redirect      = 1'b0;
    redirect_jalr = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    imem_rdata    = 32'h0;
    imem_ready    = 1'b0;
    instr_ready   = 1'b0;
    redirect      = 1'b0;
    redirect_base = 32'h0;
    redirect_imm  = 32'h0;
    redirect_jalr = 1'b0;
    step;
    step;
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    rst_n = 1'b1;
    step;
    chk("post_rst_req", {31'b0, imem_req}, 32'h1);
    chk("post_rst_addr", imem_addr, 32'h0);

    // Zero-wait streaming: one instruction every two cycles.
    imem_ready  = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      imem_rdata = 32'h0000_0013 + 32'(i) * 32'h0010_0000;
      chk("stream_req", {31'b0, imem_req}, 32'h1);
      chk("stream_addr", imem_addr, 32'(i * 4));
      chk("stream_valid0", {31'b0, instr_valid}, 32'h0);
      step;
      chk("stream_valid1", {31'b0, instr_valid}, 32'h1);
      chk("stream_instr", instr, 32'h0000_0013 + 32'(i) * 32'h0010_0000);
      chk("stream_instr_pc", instr_pc, 32'(i * 4));
      chk("stream_req_hold", {31'b0, imem_req}, 32'h0);
      step;
    end

    // Memory wait states at address 8.
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", {31'b0, imem_req}, 32'h1);
      chk("wait_addr", imem_addr, 32'h8);
      chk("wait_valid", {31'b0, instr_valid}, 32'h0);
      step;
    end
    imem_ready  = 1'b1;
    imem_rdata  = 32'h00A0_0093;
    instr_ready = 1'b0;
    step;

    // Decode stall in HOLD.
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", {31'b0, instr_valid}, 32'h1);
      chk("stall_instr", instr, 32'h00A0_0093);
      chk("stall_instr_pc", instr_pc, 32'h8);
      chk("stall_req", {31'b0, imem_req}, 32'h0);
      chk("stall_addr", imem_addr, 32'h8);
      step;
    end
    imem_ready  = 1'b0;
    instr_ready = 1'b1;
    step;
    chk("accept_addr", imem_addr, 32'hC);
    chk("accept_req", {31'b0, imem_req}, 32'h1);
    chk("accept_valid", {31'b0, instr_valid}, 32'h0);

    // Redirect coinciding with imem_ready: returned word dropped.
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    do_redirect(32'h100, 32'hFFFF_FFF0, 1'b0);
    imem_ready = 1'b0;
    chk("redir_addr", imem_addr, 32'hF0);
    chk("redir_req", {31'b0, imem_req}, 32'h1);
    chk("redir_valid", {31'b0, instr_valid}, 32'h0);
    chk("redir_instr_kept", instr, 32'h00A0_0093);

    // JALR clears bit 0.
    do_redirect(32'h201, 32'h4, 1'b1);
    chk("jalr_addr", imem_addr, 32'h204);
    chk("jalr_req", {31'b0, imem_req}, 32'h1);

    // Redirect in HOLD overrides instr_ready.
    imem_ready = 1'b1;
    imem_rdata = 32'h0000_006F;
    step;
    imem_ready = 1'b0;
    chk("hold_valid", {31'b0, instr_valid}, 32'h1);
    chk("hold_instr_pc", instr_pc, 32'h204);
    do_redirect(32'h300, 32'h0, 1'b0);
    chk("hold_redir_addr", imem_addr, 32'h300);
    chk("hold_redir_valid", {31'b0, instr_valid}, 32'h0);
    chk("hold_redir_req", {31'b0, imem_req}, 32'h1);

    // PC wrap from 0xFFFF_FFFC.
    do_redirect(32'hFFFF_FFF0, 32'hC, 1'b0);
    chk("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ready = 1'b1;
    imem_rdata = 32'h0000_0033;
    step;
    imem_ready = 1'b0;
    chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    step;
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_req", {31'b0, imem_req}, 32'h1);

    // Misaligned redirect target 0x102.
    do_redirect(32'h100, 32'h2, 1'b0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    imem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("fault_flag", {31'b0, fetch_fault}, 32'h1);
      chk("fault_req", {31'b0, imem_req}, 32'h0);
      chk("fault_valid", {31'b0, instr_valid}, 32'h0);
      step;
    end
    imem_ready = 1'b0;
    do_redirect(32'h200, 32'h0, 1'b0);
    chk("fault_clr", {31'b0, fetch_fault}, 32'h0);
    chk("fault_clr_req", {31'b0, imem_req}, 32'h1);
    chk("fault_clr_addr", imem_addr, 32'h200);
`else
    chk("misalign_addr", imem_addr, 32'h100);
    chk("misalign_req", {31'b0, imem_req}, 32'h1);
    chk("misalign_fault", {31'b0, fetch_fault}, 32'h0);
`endif

    // Asynchronous reset while holding an instruction.
    imem_ready = 1'b1;
    imem_rdata = 32'h1234_5678;
    instr_ready = 1'b0;
    step;
    imem_ready = 1'b0;
    chk("pre_rst_valid", {31'b0, instr_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("mid_rst_instr", instr, 32'h0000_0013);
    chk("mid_rst_instr_pc", instr_pc, 32'h0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    step;
    rst_n = 1'b1;
    step;
    chk("restart_req", {31'b0, imem_req}, 32'h1);
    chk("restart_addr", imem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
